// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the demux family: FSM state encodings and a clog2 helper.
package tdm_demux_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/demux_wr_decode.sv
// Binary slot index plus write strobe to one-hot shadow-bank write enables.
module demux_wr_decode #(
    parameter int unsigned SLOTS = 4,
    parameter int unsigned CW    = 2
) (
    input  logic [CW-1:0]    idx_i,
    input  logic             stb_i,
    output logic [SLOTS-1:0] wr_en_c
);

    always_comb begin
        wr_en_c = '0;
        for (int k = 0; k < SLOTS; k++) begin
            wr_en_c[k] = stb_i && (idx_i == CW'(k));
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// TDM receiver: collects SLOTS words per frame into a shadow bank and publishes
// the full frame atomically with a one-cycle valid pulse.
module tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter  int unsigned WIDTH = 4,
    parameter  int unsigned SLOTS = 4,
    localparam int unsigned CW    = clog2(SLOTS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic                   in_sof,
    input  logic [WIDTH-1:0]       in_data,
    output logic [SLOTS*WIDTH-1:0] out_data,
    output logic                   out_valid,
    output logic                   frame_err,
    output logic [CW-1:0]          cur_slot
);

    state_e                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [WIDTH-1:0]         shadow_q [SLOTS];
    logic [WIDTH-1:0]         shadow_d [SLOTS];
    logic [SLOTS*WIDTH-1:0]   out_data_q, out_data_d;
    logic [SLOTS*WIDTH-1:0]   frame_c;
    logic                     out_valid_q, out_valid_d;
    logic                     frame_err_q, frame_err_d;
    logic                     wr_stb;
    logic [CW-1:0]            wr_idx;
    logic                     publish;
    logic [SLOTS-1:0]         wr_en_c;

    demux_wr_decode #(
        .SLOTS (SLOTS),
        .CW    (CW)
    ) u_wr_decode (
        .idx_i   (wr_idx),
        .stb_i   (wr_stb),
        .wr_en_c (wr_en_c)
    );

    // Frame tracking: an SOF always restarts at slot 0, dropping any partial frame.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_stb      = 1'b0;
        wr_idx      = cnt_q;
        publish     = 1'b0;
        out_valid_d = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_sof) begin
                    wr_stb  = 1'b1;
                    wr_idx  = '0;
                    cnt_d   = CW'(1);
                    state_d = ST_RECV;
                end
            end
            ST_RECV: begin
                if (in_valid && in_sof) begin
                    frame_err_d = 1'b1;
                    wr_stb      = 1'b1;
                    wr_idx      = '0;
                    cnt_d       = CW'(1);
                end else if (in_valid) begin
                    wr_stb = 1'b1;
                    if (cnt_q == CW'(SLOTS - 1)) begin
                        publish     = 1'b1;
                        out_valid_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Shadow bank update and frame packing; the last word is merged on publish.
    always_comb begin
        frame_c = '0;
        for (int k = 0; k < SLOTS; k++) begin
            shadow_d[k] = wr_en_c[k] ? in_data : shadow_q[k];
            frame_c[k*WIDTH +: WIDTH] = shadow_d[k];
        end
        out_data_d = publish ? frame_c : out_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            for (int k = 0; k < SLOTS; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
            for (int k = 0; k < SLOTS; k++) begin
                shadow_q[k] <= shadow_d[k];
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
    assign cur_slot  = cnt_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (WIDTH=4, SLOTS=4) with hand-computed frames.
module tb_tdm_demux;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_sof;
    logic [3:0]  in_data;
    logic [15:0] out_data;
    logic        out_valid;
    logic        frame_err;
    logic [1:0]  cur_slot;

    int n_vec;
    int n_err;
    int cyc;
    int vcnt;
    int ecnt;
    int t_last;
    int t_prev;
    int v0;
    int e0;

    tdm_demux #(
        .WIDTH (4),
        .SLOTS (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_data   (in_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .frame_err (frame_err),
        .cur_slot  (cur_slot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor sampled on the falling edge, away from register updates.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                vcnt   = vcnt + 1;
                t_prev = t_last;
                t_last = cyc;
            end
            if (frame_err) ecnt = ecnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic word(input logic sof, input logic [3:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        in_sof   = sof;
        in_data  = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_sof   = 1'b0;
            in_data  = 4'h0;
        end
    endtask

    task automatic mark();
        v0 = vcnt;
        e0 = ecnt;
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0; vcnt = 0; ecnt = 0; t_last = 0; t_prev = 0;
        in_valid = 1'b0; in_sof = 1'b0; in_data = 4'h0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        chk("rst_cur_slot", 32'(cur_slot), 32'h0);
        rst = 1'b0;
        idle(2);

        // Normal frame
        mark();
        word(1'b1, 4'h3);
        word(1'b0, 4'hB);
        chk("norm_slot1", 32'(cur_slot), 32'd1);
        word(1'b0, 4'hF);
        word(1'b0, 4'hE);
        idle(1);
        chk("norm_valid", 32'(out_valid), 32'h1);
        chk("norm_data", 32'(out_data), 32'hEFB3);
        chk("norm_slot_done", 32'(cur_slot), 32'd0);
        idle(1);
        chk("norm_valid_drop", 32'(out_valid), 32'h0);
        chk("norm_data_hold", 32'(out_data), 32'hEFB3);
        idle(2);
        chk("norm_vcnt", 32'(vcnt - v0), 32'd1);
        chk("norm_ecnt", 32'(ecnt - e0), 32'd0);

        // Gaps between words
        mark();
        word(1'b1, 4'h3);
        idle(3);
        chk("gap_slot1", 32'(cur_slot), 32'd1);
        word(1'b0, 4'hB);
        idle(3);
        chk("gap_slot2", 32'(cur_slot), 32'd2);
        word(1'b0, 4'hF);
        idle(3);
        chk("gap_slot3", 32'(cur_slot), 32'd3);
        chk("gap_no_valid", 32'(vcnt - v0), 32'd0);
        word(1'b0, 4'hE);
        idle(1);
        chk("gap_valid", 32'(out_valid), 32'h1);
        chk("gap_data", 32'(out_data), 32'hEFB3);
        idle(2);

        // Early SOF aborts partial frame
        mark();
        word(1'b1, 4'h1);
        word(1'b0, 4'h2);
        word(1'b1, 4'h4);
        word(1'b0, 4'h5);
        chk("esof_err", 32'(frame_err), 32'h1);
        chk("esof_slot", 32'(cur_slot), 32'd1);
        chk("esof_data_hold", 32'(out_data), 32'hEFB3);
        word(1'b0, 4'h6);
        chk("esof_err_drop", 32'(frame_err), 32'h0);
        word(1'b0, 4'h7);
        idle(1);
        chk("esof_data", 32'(out_data), 32'h7654);
        idle(2);
        chk("esof_vcnt", 32'(vcnt - v0), 32'd1);
        chk("esof_ecnt", 32'(ecnt - e0), 32'd1);

        // Word without SOF in IDLE is discarded
        mark();
        word(1'b0, 4'hA);
        idle(1);
        chk("disc_slot", 32'(cur_slot), 32'd0);
        word(1'b1, 4'h1);
        word(1'b0, 4'h2);
        word(1'b0, 4'h3);
        word(1'b0, 4'h4);
        idle(1);
        chk("disc_data", 32'(out_data), 32'h4321);
        idle(2);
        chk("disc_vcnt", 32'(vcnt - v0), 32'd1);
        chk("disc_ecnt", 32'(ecnt - e0), 32'd0);

        // Back-to-back frames, zero bubble
        mark();
        word(1'b1, 4'h3);
        word(1'b0, 4'hB);
        word(1'b0, 4'hF);
        word(1'b0, 4'hE);
        word(1'b1, 4'hC);
        chk("b2b_valid1", 32'(out_valid), 32'h1);
        chk("b2b_data1", 32'(out_data), 32'hEFB3);
        word(1'b0, 4'h3);
        chk("b2b_slot", 32'(cur_slot), 32'd1);
        word(1'b0, 4'hC);
        word(1'b0, 4'h3);
        idle(1);
        chk("b2b_valid2", 32'(out_valid), 32'h1);
        chk("b2b_data2", 32'(out_data), 32'h3C3C);
        idle(2);
        chk("b2b_vcnt", 32'(vcnt - v0), 32'd2);
        chk("b2b_spacing", 32'(t_last - t_prev), 32'd4);
        chk("b2b_ecnt", 32'(ecnt - e0), 32'd0);

        // Asynchronous reset mid-frame
        word(1'b1, 4'h1);
        word(1'b0, 4'h2);
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_data", 32'(out_data), 32'h0);
        chk("arst_slot", 32'(cur_slot), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mark();
        word(1'b0, 4'h3);
        word(1'b0, 4'h4);
        idle(3);
        chk("arst_data_after", 32'(out_data), 32'h0);
        chk("arst_vcnt", 32'(vcnt - v0), 32'd0);
        chk("arst_slot_after", 32'(cur_slot), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
